hazard_scoreboard: RTL and testbench

//  Parametrised hazard and forwarding controller for the pipelined processor.

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight register writers after decode,
// resolves decode sources to forwarding selects and raises a load-use stall.
module hazard_scoreboard #(
    parameter int REG_AW   = 3,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [SEL_W-1:0]  fwd_sel1_o,
    output logic [SEL_W-1:0]  fwd_sel2_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             load_q, load_d;
    logic [DEPTH-1:0][REG_AW-1:0] dest_q, dest_d;
    logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

    logic             haz1, haz2;
    logic [SEL_W-1:0] sel1, sel2;

    // Returns {hazard, select}; the youngest matching entry alone decides.
    function automatic logic [SEL_W:0] resolve(
        input logic [REG_AW-1:0] src,
        input logic              used
    );
        logic             hit;
        logic             hit_load;
        int               hit_idx;
        logic [SEL_W:0]   res;
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_idx  = 0;
        res      = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && (dest_q[k] == src)) begin
                hit      = 1'b1;
                hit_load = load_q[k];
                hit_idx  = k;
            end
        end
        if (used && hit) begin
            if (hit_load && (hit_idx < LOAD_LAT)) begin
                res[SEL_W] = 1'b1;
            end else begin
                res[SEL_W-1:0] = SEL_W'(hit_idx + 1);
            end
        end
        return res;
    endfunction

    always_comb begin
        {haz1, sel1} = resolve(id_src1, id_src1_used);
        {haz2, sel2} = resolve(id_src2, id_src2_used);
    end

    always_comb begin
        stall_o    = id_valid & ~flush_i & (haz1 | haz2);
        fwd_sel1_o = '0;
        fwd_sel2_o = '0;
        if (id_valid && !flush_i && !stall_o) begin
            fwd_sel1_o = sel1;
            fwd_sel2_o = sel2;
        end
    end

    // Entry 0 takes the decode instruction unless it is stalled, flushed or not a writer.
    always_comb begin
        valid_d    = '0;
        load_d     = '0;
        dest_d     = '0;
        valid_d[0] = id_valid & id_reg_write & ~stall_o & ~flush_i;
        load_d[0]  = id_mem_read;
        dest_d[0]  = id_dest;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            load_d[k]  = load_q[k-1];
            dest_d[k]  = dest_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            load_q      <= '0;
            dest_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            load_q      <= load_d;
            dest_q      <= dest_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a queue-based model of in-flight writers checked
// every cycle, plus directed scenarios with literal expectations.
module tb_hazard_scoreboard;

    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_src1 = '0;
    logic       id_src1_used = 1'b0;
    logic [2:0] id_src2 = '0;
    logic       id_src2_used = 1'b0;
    logic [2:0] id_dest = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       flush_i = 1'b0;

    logic        stall_a, stall_b;
    logic [1:0]  f1_a, f2_a, f1_b, f2_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush_i(flush_i), .stall_o(stall_a), .fwd_sel1_o(f1_a), .fwd_sel2_o(f2_a),
        .stall_cnt_o(cnt_a)
    );

    hazard_scoreboard #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush_i(flush_i), .stall_o(stall_b), .fwd_sel1_o(f1_b), .fwd_sel2_o(f2_b),
        .stall_cnt_o(cnt_b)
    );

    // Model: mq[k] is whatever entered EX k+1 cycles ago (bubbles included).
    typedef struct {
        bit       v;
        bit [2:0] dest;
        bit       ld;
    } instr_t;

    instr_t mq[$];
    int     m_cnt16 = 0;
    int     m_cnt2  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void eval_src(input bit [2:0] s, input bit used,
                                     output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (!used) return;
        for (int k = 0; k < mq.size() && k < DEPTH; k++) begin
            if (mq[k].v && mq[k].dest == s) begin
                if (mq[k].ld && k < LOAD_LAT) haz = 1'b1;
                else sel = k + 1;
                return;
            end
        end
    endfunction

    function automatic void expect_all(output bit st, output int s1, output int s2);
        bit h1, h2;
        eval_src(id_src1, id_src1_used, s1, h1);
        eval_src(id_src2, id_src2_used, s2, h2);
        st = id_valid && !flush_i && (h1 || h2);
        if (st || flush_i || !id_valid) begin
            s1 = 0;
            s2 = 0;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_cnt16 = 0;
                m_cnt2  = 0;
            end else begin
                bit     st;
                int     s1, s2;
                instr_t ni;
                expect_all(st, s1, s2);
                ni.v    = id_valid && id_reg_write && !st && !flush_i;
                ni.dest = id_dest;
                ni.ld   = id_mem_read;
                mq.push_front(ni);
                if (mq.size() > DEPTH) void'(mq.pop_back());
                if (st) begin
                    if (m_cnt16 < 65535) m_cnt16++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                bit st;
                int s1, s2;
                expect_all(st, s1, s2);
                chk("m_stall", int'(stall_a), int'(st));
                chk("m_stall_sat", int'(stall_b), int'(st));
                if (id_valid) begin
                    chk("m_fwd1", int'(f1_a), s1);
                    chk("m_fwd2", int'(f2_a), s2);
                    chk("m_fwd1_sat", int'(f1_b), s1);
                    chk("m_fwd2_sat", int'(f2_b), s2);
                end
                chk("m_cnt", int'(cnt_a), m_cnt16);
                chk("m_cnt_sat", int'(cnt_b), m_cnt2);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit [2:0] s1, input bit u1,
                         input bit [2:0] s2, input bit u2, input bit [2:0] d,
                         input bit rw, input bit mr, input bit fl);
        id_valid     = v;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_src2_used = u2;
        id_dest      = d;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush_i      = fl;
    endtask

    initial begin
        repeat (2) tick;
        rst = 1'b0;
        #1;
        chk("reset_stall", int'(stall_a), 0);
        chk("reset_cnt", int'(cnt_a), 0);

        // ADD r1; SUB r4 <- r1,r2; then reader of r1 one slot later
        drive(1, 3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 0);
        #1 chk("add_fwd1_none", int'(f1_a), 0);
        tick;
        drive(1, 3'd1, 1, 3'd2, 1, 3'd4, 1, 0, 0);
        #1 chk("sub_fwd1", int'(f1_a), 1);
        chk("sub_fwd2", int'(f2_a), 0);
        chk("sub_stall", int'(stall_a), 0);
        tick;
        drive(1, 3'd1, 1, 3'd0, 0, 3'd5, 1, 0, 0);
        #1 chk("gap_fwd1", int'(f1_a), 2);
        tick;

        // LDD r3 then use: one stall cycle, then forward from MEM
        drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0);
        tick;
        drive(1, 3'd3, 1, 3'd6, 1, 3'd7, 1, 0, 0);
        #1 chk("lu_stall", int'(stall_a), 1);
        chk("lu_cnt_before", int'(cnt_a), 0);
        tick;
        chk("lu_stall_done", int'(stall_a), 0);
        chk("lu_fwd1", int'(f1_a), 2);
        chk("lu_cnt_after", int'(cnt_a), 1);
        tick;
        drive(1, 3'd7, 1, 3'd3, 1, 3'd0, 0, 0, 0);
        #1 chk("bubble_fwd1", int'(f1_a), 1);
        chk("bubble_fwd2", int'(f2_a), 3);
        tick;

        // two writers of r2: youngest wins
        drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0, 0);
        tick;
        drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0, 0);
        tick;
        drive(1, 3'd2, 1, 3'd2, 1, 3'd0, 0, 0, 0);
        #1 chk("young_fwd1", int'(f1_a), 1);
        chk("young_fwd2", int'(f2_a), 1);
        tick;

        // load-use with flush: flush wins, flushed writer never tracked
        drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0);
        tick;
        drive(1, 3'd5, 1, 3'd0, 0, 3'd5, 1, 0, 1);
        #1 chk("flush_stall", int'(stall_a), 0);
        chk("flush_fwd1", int'(f1_a), 0);
        tick;
        drive(1, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0, 0);
        #1 chk("flush_cnt", int'(cnt_a), 1);
        chk("flush_e0_empty", int'(f1_a), 2);
        tick;

        // asynchronous reset in the middle of a stall
        drive(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1, 0);
        tick;
        drive(1, 3'd6, 1, 3'd6, 1, 3'd1, 1, 0, 0);
        #1 chk("pre_rst_stall", int'(stall_a), 1);
        rst = 1'b1;
        #1 chk("arst_stall", int'(stall_a), 0);
        chk("arst_fwd1", int'(f1_a), 0);
        chk("arst_fwd2", int'(f2_a), 0);
        chk("arst_cnt", int'(cnt_a), 0);
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        tick;
        rst = 1'b0;

        // five load-use stalls: narrow counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0);
            tick;
            drive(1, 3'd1, 1, 3'd0, 0, 3'd3, 1, 0, 0);
            tick;
            tick;
        end
        chk("sat_cnt16", int'(cnt_a), 5);
        chk("sat_cnt2", int'(cnt_b), 3);

        // matching register but not read: no stall, no forward
        drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0);
        tick;
        drive(1, 3'd2, 0, 3'd2, 0, 3'd4, 1, 0, 0);
        #1 chk("unused_stall", int'(stall_a), 0);
        chk("unused_fwd1", int'(f1_a), 0);
        chk("unused_fwd2", int'(f2_a), 0);
        tick;
        drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0);
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
